mc_alu_sequencer: RTL and testbench

Multicycle control FSM that sequences the shared ALU and its operand muxes for the supported instruction subset. It drives the ALU source-A select, the 3-bit source-B select, the ALU operation and the PC, IR, memory and register-file write enables. It sits between the instruction register fields and the datapath control inputs, with one instruction in flight at a time.

---
 rtl/mc_alu_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_mc_alu_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mc_alu_sequencer.sv
// mc_alu_sequencer: multicycle control FSM for the shared-ALU datapath.
// Moore machine; the control word is registered and decoded from the next
// state, so outputs change together with state_dbg. An asynchronous reset
// clears state and outputs at once, which blocks any pending write.
module mc_alu_sequencer #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       alu_srcA,
  output logic [2:0] alu_srcB,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       ir_write,
  output logic       mem_wr,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       aluout_write,
  output logic       exc,
  output logic [4:0] state_dbg
);

  typedef enum logic [4:0] {
    RESET     = 5'd0,  FETCH0  = 5'd1,  FETCH_W  = 5'd2,  FETCH2 = 5'd3,
    DECODE    = 5'd4,  R_EXEC  = 5'd5,  R_WB     = 5'd6,  ADDI_EXEC = 5'd7,
    ADDI_WB   = 5'd8,  MEM_ADDR = 5'd9, LW_RD    = 5'd10, LW_W   = 5'd11,
    LW_WB     = 5'd12, SW_WR   = 5'd13, BEQ      = 5'd14, JUMP   = 5'd15,
    EXC       = 5'd16
  } state_t;

  typedef struct packed {
    logic       src_a;
    logic [2:0] src_b;
    logic [2:0] op;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       mem_wr;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       aluout_write;
    logic       exc;
  } ctl_t;

  localparam logic [2:0] OP_PASS = 3'b000, OP_ADD = 3'b001,
                         OP_SUB  = 3'b010, OP_AND = 3'b011;
  // Wait counter preload: the first wait cycle is the state entry itself.
  localparam logic [1:0] WAIT_LOAD = 2'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

  state_t     state, nxt;
  ctl_t       ctl;
  logic [1:0] wcnt, wcnt_nxt;
  logic       f_add, f_sub, f_and;

  assign f_add = (funct == 6'h20);
  assign f_sub = (funct == 6'h22);
  assign f_and = (funct == 6'h24);

  // Control word for a given state; only R_EXEC looks at funct.
  function automatic ctl_t decode(state_t s, logic add, logic sub, logic andf);
    ctl_t c;
    c = '0;
    case (s)
      FETCH0, FETCH_W: begin
        c.src_b = 3'b001; c.op = OP_ADD;
      end
      FETCH2: begin
        c.src_b = 3'b001; c.op = OP_ADD; c.ir_write = 1'b1; c.pc_write = 1'b1;
      end
      DECODE: begin
        c.src_b = 3'b011; c.op = OP_ADD; c.aluout_write = 1'b1;
      end
      R_EXEC: begin
        c.src_a = 1'b1;
        c.src_b = 3'b000;
        if (add)       begin c.op = OP_ADD; c.aluout_write = 1'b1; end
        else if (sub)  begin c.op = OP_SUB; c.aluout_write = 1'b1; end
        else if (andf) begin c.op = OP_AND; c.aluout_write = 1'b1; end
        else           c.op = OP_PASS;
      end
      R_WB: begin
        c.reg_write = 1'b1; c.reg_dst = 1'b1;
      end
      ADDI_EXEC, MEM_ADDR: begin
        c.src_a = 1'b1; c.src_b = 3'b010; c.op = OP_ADD; c.aluout_write = 1'b1;
      end
      ADDI_WB: c.reg_write = 1'b1;
      LW_RD, LW_W: c.iord = 1'b1;
      LW_WB: begin
        c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
      end
      SW_WR: begin
        c.iord = 1'b1; c.mem_wr = 1'b1;
      end
      BEQ: begin
        c.src_a = 1'b1; c.src_b = 3'b000; c.op = OP_SUB;
        c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      end
      JUMP: begin
        c.pc_write = 1'b1; c.pc_source = 2'b10;
      end
      EXC: c.exc = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state and memory-wait counter logic.
  always_comb begin
    nxt      = state;
    wcnt_nxt = wcnt;
    case (state)
      RESET:  nxt = FETCH0;
      FETCH0: begin
        if (MEM_WAIT == 0) nxt = FETCH2;
        else begin nxt = FETCH_W; wcnt_nxt = WAIT_LOAD; end
      end
      FETCH_W: begin
        if (wcnt == 2'd0) nxt = FETCH2;
        else wcnt_nxt = wcnt - 2'd1;
      end
      FETCH2: nxt = DECODE;
      DECODE: begin
        case (opcode)
          6'h00:        nxt = R_EXEC;
          6'h08:        nxt = ADDI_EXEC;
          6'h23, 6'h2B: nxt = MEM_ADDR;
          6'h04:        nxt = BEQ;
          6'h02:        nxt = JUMP;
          default:      nxt = EXC;
        endcase
      end
      R_EXEC: begin
        if (!(f_add || f_sub || f_and))        nxt = EXC;
        else if ((f_add || f_sub) && overflow) nxt = EXC;
        else                                   nxt = R_WB;
      end
      ADDI_EXEC: nxt = overflow ? EXC : ADDI_WB;
      MEM_ADDR:  nxt = (opcode == 6'h23) ? LW_RD : SW_WR;
      LW_RD: begin
        if (MEM_WAIT == 0) nxt = LW_WB;
        else begin nxt = LW_W; wcnt_nxt = WAIT_LOAD; end
      end
      LW_W: begin
        if (wcnt == 2'd0) nxt = LW_WB;
        else wcnt_nxt = wcnt - 2'd1;
      end
      default: nxt = FETCH0;
    endcase
  end

  // State, wait counter and registered control word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET;
      wcnt  <= 2'd0;
      ctl   <= '0;
    end else begin
      state <= nxt;
      wcnt  <= wcnt_nxt;
      ctl   <= decode(nxt, f_add, f_sub, f_and);
    end
  end

  // Branch decision uses zero in the datapath via pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  assign alu_srcA      = ctl.src_a;
  assign alu_srcB      = ctl.src_b;
  assign alu_op        = ctl.op;
  assign pc_write      = ctl.pc_write;
  assign pc_write_cond = ctl.pc_write_cond;
  assign pc_source     = ctl.pc_source;
  assign ir_write      = ctl.ir_write;
  assign mem_wr        = ctl.mem_wr;
  assign iord          = ctl.iord;
  assign reg_write     = ctl.reg_write;
  assign reg_dst       = ctl.reg_dst;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign aluout_write  = ctl.aluout_write;
  assign exc           = ctl.exc;
  assign state_dbg     = state;

endmodule

// File: tb/tb_mc_alu_sequencer.sv
// Scoreboard bench for mc_alu_sequencer: stimulus pushes the expected
// per-cycle control word, a negedge monitor pops and compares.
module tb_mc_alu_sequencer;

  logic clk = 1'b0;
  logic rst1, rst0;
  logic [5:0] opcode, funct;
  logic zero, overflow;

  // Per-DUT outputs: index 1 = MEM_WAIT 1, index 0 = MEM_WAIT 0.
  logic       sa   [2];
  logic [2:0] sb   [2];
  logic [2:0] op   [2];
  logic       pcw  [2];
  logic       pcwc [2];
  logic [1:0] pcs  [2];
  logic       irw  [2];
  logic       mw   [2];
  logic       iord [2];
  logic       rw   [2];
  logic       rd   [2];
  logic       m2r  [2];
  logic       aow  [2];
  logic       exc  [2];
  logic [4:0] st   [2];

  always #5 clk = ~clk;

  mc_alu_sequencer #(.MEM_WAIT(1)) u1 (
    .clk(clk), .reset(rst1), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .alu_srcA(sa[1]), .alu_srcB(sb[1]), .alu_op(op[1]),
    .pc_write(pcw[1]), .pc_write_cond(pcwc[1]), .pc_source(pcs[1]),
    .ir_write(irw[1]), .mem_wr(mw[1]), .iord(iord[1]), .reg_write(rw[1]),
    .reg_dst(rd[1]), .mem_to_reg(m2r[1]), .aluout_write(aow[1]),
    .exc(exc[1]), .state_dbg(st[1]));

  mc_alu_sequencer #(.MEM_WAIT(0)) u0 (
    .clk(clk), .reset(rst0), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .alu_srcA(sa[0]), .alu_srcB(sb[0]), .alu_op(op[0]),
    .pc_write(pcw[0]), .pc_write_cond(pcwc[0]), .pc_source(pcs[0]),
    .ir_write(irw[0]), .mem_wr(mw[0]), .iord(iord[0]), .reg_write(rw[0]),
    .reg_dst(rd[0]), .mem_to_reg(m2r[0]), .aluout_write(aow[0]),
    .exc(exc[0]), .state_dbg(st[0]));

  // Layout: {state, srcA, srcB, op, pcw,pcwc,pcs, irw,mw,iord, rw,rd,m2r, aow,exc}
  localparam logic [23:0]
    RST  = {5'd0,  1'b0, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b00},
    F0   = {5'd1,  1'b0, 3'b001, 3'b001, 4'b0000, 3'b000, 3'b000, 2'b00},
    FW   = {5'd2,  1'b0, 3'b001, 3'b001, 4'b0000, 3'b000, 3'b000, 2'b00},
    F2   = {5'd3,  1'b0, 3'b001, 3'b001, 4'b1000, 3'b100, 3'b000, 2'b00},
    DEC  = {5'd4,  1'b0, 3'b011, 3'b001, 4'b0000, 3'b000, 3'b000, 2'b10},
    RADD = {5'd5,  1'b1, 3'b000, 3'b001, 4'b0000, 3'b000, 3'b000, 2'b10},
    RSUB = {5'd5,  1'b1, 3'b000, 3'b010, 4'b0000, 3'b000, 3'b000, 2'b10},
    RAND = {5'd5,  1'b1, 3'b000, 3'b011, 4'b0000, 3'b000, 3'b000, 2'b10},
    RBAD = {5'd5,  1'b1, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b00},
    RWB  = {5'd6,  1'b0, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b110, 2'b00},
    AE   = {5'd7,  1'b1, 3'b010, 3'b001, 4'b0000, 3'b000, 3'b000, 2'b10},
    AWB  = {5'd8,  1'b0, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b100, 2'b00},
    MA   = {5'd9,  1'b1, 3'b010, 3'b001, 4'b0000, 3'b000, 3'b000, 2'b10},
    LRD  = {5'd10, 1'b0, 3'b000, 3'b000, 4'b0000, 3'b001, 3'b000, 2'b00},
    LWW  = {5'd11, 1'b0, 3'b000, 3'b000, 4'b0000, 3'b001, 3'b000, 2'b00},
    LWB  = {5'd12, 1'b0, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b101, 2'b00},
    SW   = {5'd13, 1'b0, 3'b000, 3'b000, 4'b0000, 3'b011, 3'b000, 2'b00},
    BEQ  = {5'd14, 1'b1, 3'b000, 3'b010, 4'b0101, 3'b000, 3'b000, 2'b00},
    JMP  = {5'd15, 1'b0, 3'b000, 3'b000, 4'b1010, 3'b000, 3'b000, 2'b00},
    EXC  = {5'd16, 1'b0, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b01};

  typedef logic [23:0] seq_t [8];
  typedef struct { logic [23:0] v; string nm; } exp_t;

  exp_t q [2][$];
  int checks = 0;
  int errors = 0;

  function automatic logic [23:0] obs(int d);
    return {st[d], sa[d], sb[d], op[d], pcw[d], pcwc[d], pcs[d],
            irw[d], mw[d], iord[d], rw[d], rd[d], m2r[d], aow[d], exc[d]};
  endfunction

  // Monitor: one comparison per DUT per cycle while expectations are queued.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (q[d].size() > 0) begin
        exp_t e;
        logic [23:0] a;
        e = q[d].pop_front();
        a = obs(d);
        checks++;
        if (a !== e.v) begin
          errors++;
          $display("FAIL %s dut%0d: got %h expected %h", e.nm, d, a, e.v);
        end
      end
    end
  end

  task automatic push(input int d, input string nm, input int n, input seq_t s);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.v = s[i];
      e.nm = $sformatf("%s_c%0d", nm, i + 1);
      q[d].push_back(e);
    end
  endtask

  // Called just after the edge that enters FETCH0; returns just after the
  // edge that enters the following FETCH0.
  task automatic run(input int d, input string nm, input logic [5:0] opc,
                     input logic [5:0] fn, input logic ov, input int n,
                     input seq_t s);
    opcode = opc; funct = fn; overflow = ov;
    push(d, nm, n, s);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst1 = 1'b1; rst0 = 1'b1; opcode = 6'h00; funct = 6'h20;
    zero = 1'b0; overflow = 1'b0;
    push(1, "reset1", 1, '{RST, RST, RST, RST, RST, RST, RST, RST});
    push(0, "reset0", 1, '{RST, RST, RST, RST, RST, RST, RST, RST});
    @(negedge clk); #1;
    rst1 = 1'b0;
    @(posedge clk); #1;

    run(1, "r_add",   6'h00, 6'h20, 1'b0, 6, '{F0, FW, F2, DEC, RADD, RWB, RST, RST});
    run(1, "r_sub_ov",6'h00, 6'h22, 1'b1, 6, '{F0, FW, F2, DEC, RSUB, EXC, RST, RST});
    run(1, "r_and_ov",6'h00, 6'h24, 1'b1, 6, '{F0, FW, F2, DEC, RAND, RWB, RST, RST});
    run(1, "r_badfn", 6'h00, 6'h21, 1'b0, 6, '{F0, FW, F2, DEC, RBAD, EXC, RST, RST});
    run(1, "addi",    6'h08, 6'h00, 1'b0, 6, '{F0, FW, F2, DEC, AE, AWB, RST, RST});
    run(1, "addi_ov", 6'h08, 6'h00, 1'b1, 6, '{F0, FW, F2, DEC, AE, EXC, RST, RST});
    run(1, "lw_ov",   6'h23, 6'h00, 1'b1, 8, '{F0, FW, F2, DEC, MA, LRD, LWW, LWB});
    run(1, "sw",      6'h2B, 6'h00, 1'b0, 6, '{F0, FW, F2, DEC, MA, SW, RST, RST});
    run(1, "beq",     6'h04, 6'h00, 1'b0, 5, '{F0, FW, F2, DEC, BEQ, RST, RST, RST});
    run(1, "jump",    6'h02, 6'h00, 1'b0, 5, '{F0, FW, F2, DEC, JMP, RST, RST, RST});
    run(1, "bad_op",  6'h3F, 6'h00, 1'b0, 5, '{F0, FW, F2, DEC, EXC, RST, RST, RST});

    // Reset during LW_W: outputs clear before any further edge, stay clear,
    // FETCH0 one edge after release and the load never writes back.
    opcode = 6'h23; overflow = 1'b0;
    push(1, "lw_rst", 6, '{F0, FW, F2, DEC, MA, LRD, RST, RST});
    repeat (6) @(posedge clk);
    #1;
    rst1 = 1'b1;
    push(1, "in_rst", 3, '{RST, RST, RST, RST, RST, RST, RST, RST});
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b0;
    @(posedge clk); #1;
    run(1, "post_rst", 6'h00, 6'h20, 1'b0, 6, '{F0, FW, F2, DEC, RADD, RWB, RST, RST});

    // MEM_WAIT = 0 instance: wait states are skipped.
    rst1 = 1'b1;
    rst0 = 1'b0;
    @(posedge clk); #1;
    run(0, "r_add_w0", 6'h00, 6'h20, 1'b0, 5, '{F0, F2, DEC, RADD, RWB, RST, RST, RST});
    run(0, "lw_w0",    6'h23, 6'h00, 1'b0, 6, '{F0, F2, DEC, MA, LRD, LWB, RST, RST});
    run(0, "beq_w0",   6'h04, 6'h00, 1'b0, 4, '{F0, F2, DEC, BEQ, RST, RST, RST, RST});

    repeat (2) @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (q[d].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d: %0d left, expected 0", d, q[d].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
